// File: rtl/pong_input_pkg.sv
// Shared definitions for the pong input path (pad reader, debouncers, input bridge).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_input_pkg;

    // SNES serial frame geometry: 16 shifted bits, the low 12 are real buttons
    localparam int SNES_BITS = 16;
    localparam int PAD_BTNS  = 12;

    // Button positions in the shifted frame and in the published vectors
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // Pad poll sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } pad_state_t;

    // Input source selection understood by input_bridge
    typedef enum logic [1:0] {
        INPUT_MODE_BUTTONS = 2'b00,
        INPUT_MODE_PAD     = 2'b01
    } input_mode_t;

    // A connected pad shifts its four unused trailing bits as released (1);
    // an unplugged port reads all zeros through the board pull-down.
    function automatic logic pad_detect(input logic [SNES_BITS-1:0] raw);
        return raw[SNES_BITS-1:PAD_BTNS] == 4'b1111;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous inputs (pads, push buttons).
// Latency: 2 clk cycles from input to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/snes_pad_reader.sv
// Polls two SNES pads on a shared latch/clock and publishes active-high button vectors.
// Latency: frame_valid 34*HALF_CYC cycles after pad_latch rises; one frame every POLL_CYCLES.
// Backpressure: none; free-running, results held until the next frame. Option: SNES_PAD_PRESENT_EN.
module snes_pad_reader
    import pong_input_pkg::*;
#(
    parameter int POLL_CYCLES = 833_333,
    parameter int HALF_CYC    = 300
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          pad_data,
    output logic                pad_latch,
    output logic                pad_clk,
    output logic [PAD_BTNS-1:0] buttons_p1,
    output logic [PAD_BTNS-1:0] buttons_p2,
    output logic [1:0]          present,
    output logic                frame_valid
);

    localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int PH_W   = $clog2(2 * HALF_CYC);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * HALF_CYC - 1);
    localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_CYC - 1);
    localparam logic [3:0]        BIT_LAST   = 4'(SNES_BITS - 1);

    // Without the presence check the trailing four bits are never looked at,
    // so only the button bits are kept.
`ifdef SNES_PAD_PRESENT_EN
    localparam int RAW_W = SNES_BITS;
`else
    localparam int RAW_W = PAD_BTNS;
`endif

    pad_state_t        state;
    logic [POLL_W-1:0] poll_cnt;
    logic [PH_W-1:0]   phase_cnt;
    logic [3:0]        bit_cnt;
    logic [RAW_W-1:0]  raw_p1;
    logic [RAW_W-1:0]  raw_p2;
    logic [1:0]        pad_sync;

    sync_2ff #(
        .WIDTH (2)
    ) u_pad_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_data),
        .q   (pad_sync)
    );

`ifdef SNES_PAD_PRESENT_EN
    logic p1_ok;
    logic p2_ok;

    assign p1_ok = pad_detect(raw_p1);
    assign p2_ok = pad_detect(raw_p2);
`else
    assign present = 2'b11;
`endif

    // Free-running frame-rate timebase; a frame only starts when it reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // Frame sequencer: drives latch/clock, captures bits, publishes results
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            bit_cnt     <= '0;
            raw_p1      <= '0;
            raw_p2      <= '0;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b1;
            buttons_p1  <= '0;
            buttons_p2  <= '0;
            frame_valid <= 1'b0;
`ifdef SNES_PAD_PRESENT_EN
            present     <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (poll_cnt == '0) begin
                        state     <= ST_LATCH;
                        pad_latch <= 1'b1;
                        pad_clk   <= 1'b1;
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                    end
                end

                ST_LATCH: begin
                    if (phase_cnt == LATCH_LAST) begin
                        state     <= ST_CLK_LO;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_CLK_LO: begin
                    if (phase_cnt == HALF_LAST) begin
                        // Sample at the very end of the low phase, just before the
                        // rising edge that makes the pad advance to the next bit.
                        if (int'(bit_cnt) < RAW_W) begin
                            raw_p1[bit_cnt] <= pad_sync[0];
                            raw_p2[bit_cnt] <= pad_sync[1];
                        end
                        state     <= ST_CLK_HI;
                        pad_clk   <= 1'b1;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_CLK_HI: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            // All 16 bits in hand: publish on entry to DONE so the
                            // strobe and the new vectors appear in the same cycle.
                            state       <= ST_DONE;
                            frame_valid <= 1'b1;
`ifdef SNES_PAD_PRESENT_EN
                            present    <= {p2_ok, p1_ok};
                            buttons_p1 <= p1_ok ? ~raw_p1[PAD_BTNS-1:0] : '0;
                            buttons_p2 <= p2_ok ? ~raw_p2[PAD_BTNS-1:0] : '0;
`else
                            buttons_p1 <= ~raw_p1[PAD_BTNS-1:0];
                            buttons_p2 <= ~raw_p2[PAD_BTNS-1:0];
`endif
                        end else begin
                            state   <= ST_CLK_LO;
                            pad_clk <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state     <= ST_IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_pad_reader.sv
`timescale 1ns/1ps
module tb_snes_pad_reader;

    localparam int HALF = 4;
    localparam int POLL = 200;
    localparam int FV_AT = 34 * HALF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [11:0] buttons_p1;
    logic [11:0] buttons_p2;
    logic [1:0]  present;
    logic        frame_valid;

    always #5 clk = ~clk;

    snes_pad_reader #(
        .POLL_CYCLES (POLL),
        .HALF_CYC    (HALF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pad_data    (pad_data),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .buttons_p1  (buttons_p1),
        .buttons_p2  (buttons_p2),
        .present     (present),
        .frame_valid (frame_valid)
    );

    // ---------------- behavioural pad model ----------------
    // A pad presents bit 0 after latch and advances one bit per rising pad_clk;
    // past bit 15 it reads 1. An unplugged port reads 0 (pull-down).
    logic [15:0] word_p1 = 16'hFFFF;
    logic [15:0] word_p2 = 16'hFFFF;
    logic [1:0]  plugged = 2'b11;
    int          shift_idx = 99;
    logic [1:0]  model_val;
    logic        direct_mode = 1'b0;
    logic [1:0]  direct_val = 2'b11;

    always @(posedge pad_latch) shift_idx = 0;
    always @(posedge pad_clk) if (!pad_latch && shift_idx < 16) shift_idx = shift_idx + 1;

    always_comb begin
        model_val = 2'b00;
        if (plugged[0]) model_val[0] = (shift_idx < 16) ? word_p1[shift_idx[3:0]] : 1'b1;
        if (plugged[1]) model_val[1] = (shift_idx < 16) ? word_p2[shift_idx[3:0]] : 1'b1;
    end

    assign pad_data = direct_mode ? direct_val : model_val;

    // ---------------- reference rules ----------------
    function automatic logic [11:0] exp_btn(input logic [15:0] raw);
`ifdef SNES_PAD_PRESENT_EN
        return (raw[15:12] == 4'hF) ? ~raw[11:0] : 12'h000;
`else
        return ~raw[11:0];
`endif
    endfunction

    function automatic logic exp_pres(input logic [15:0] raw);
`ifdef SNES_PAD_PRESENT_EN
        return raw[15:12] == 4'hF;
`else
        return (raw == raw);
`endif
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 260; i++) begin
            step();
            if (frame_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_latch_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        prev = pad_latch;
        for (int i = 0; i < 400; i++) begin
            step();
            if (pad_latch && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = pad_latch;
        end
    endtask

    // Called just after the latch-rise edge; for each bit the line holds o[i]
    // and switches to n[i] 'lead' cycles before that bit's sample edge.
    task automatic drive_lead(input logic [15:0] o, input logic [15:0] n, input int lead);
        int e;
        e = 0;
        for (int i = 0; i < 16; i++) begin
            int s;
            s = 12 + 8 * i;
            direct_val = {2{o[i]}};
            while (e < s - lead) begin step(); e++; end
            direct_val = {2{n[i]}};
            while (e < s) begin step(); e++; end
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [1:0]  plug;
        logic [11:0] e1;
        logic [11:0] e2;
        logic [1:0]  ep;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int fv_seen;
        int changes;
        logic [15:0] w1, w2, e1, e2;
        logic [1:0] plug;
        logic [1:0] rst_pres;

`ifdef SNES_PAD_PRESENT_EN
        rst_pres = 2'b00;
        vecs[0] = '{"up_a",       16'hFEEF, 16'hFFFF, 2'b11, 12'h110, 12'h000, 2'b11};
        vecs[1] = '{"p2_unplug",  16'hFFFF, 16'hFFFF, 2'b01, 12'h000, 12'h000, 2'b01};
        vecs[2] = '{"both_unplug",16'hFFFF, 16'hFFFF, 2'b00, 12'h000, 12'h000, 2'b00};
        vecs[3] = '{"all_press",  16'hF000, 16'hFFFF, 2'b11, 12'hFFF, 12'h000, 2'b11};
        vecs[4] = '{"bad_tail",   16'h0F0F, 16'hFFFF, 2'b11, 12'h000, 12'h000, 2'b10};
        vecs[5] = '{"p2_r_b",     16'hFFFF, 16'hF7FE, 2'b11, 12'h000, 12'h801, 2'b11};
`else
        rst_pres = 2'b11;
        vecs[0] = '{"up_a",       16'hFEEF, 16'hFFFF, 2'b11, 12'h110, 12'h000, 2'b11};
        vecs[1] = '{"p2_unplug",  16'hFFFF, 16'hFFFF, 2'b01, 12'h000, 12'hFFF, 2'b11};
        vecs[2] = '{"both_unplug",16'hFFFF, 16'hFFFF, 2'b00, 12'hFFF, 12'hFFF, 2'b11};
        vecs[3] = '{"all_press",  16'hF000, 16'hFFFF, 2'b11, 12'hFFF, 12'h000, 2'b11};
        vecs[4] = '{"bad_tail",   16'h0F0F, 16'hFFFF, 2'b11, 12'h0F0, 12'h000, 2'b11};
        vecs[5] = '{"p2_r_b",     16'hFFFF, 16'hF7FE, 2'b11, 12'h000, 12'h801, 2'b11};
`endif

        // ---- reset state ----
        repeat (3) step();
        check("rst_latch", 16'(pad_latch), 16'h0);
        check("rst_clk", 16'(pad_clk), 16'h1);
        check("rst_b1", 16'(buttons_p1), 16'h0);
        check("rst_b2", 16'(buttons_p2), 16'h0);
        check("rst_present", 16'(present), 16'(rst_pres));
        check("rst_fv", 16'(frame_valid), 16'h0);

        // ---- pad-side waveform over two poll periods ----
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2 * POLL; k++) begin
            int m;
            logic el, ec, ef;
            step();
            m  = k % POLL;
            el = (m < 2 * HALF);
            ec = (m < 2 * HALF || m >= FV_AT) ? 1'b1 : (((m - 2 * HALF) % (2 * HALF)) >= HALF);
            ef = (m == FV_AT);
            check($sformatf("wave_latch_k%0d", k), 16'(pad_latch), 16'(el));
            check($sformatf("wave_clk_k%0d", k), 16'(pad_clk), 16'(ec));
            check($sformatf("wave_fv_k%0d", k), 16'(frame_valid), 16'(ef));
        end

        // ---- table-driven frames ----
        for (int v = 0; v < 6; v++) begin
            wait_fv(ok);
            check({vecs[v].name, "_sync"}, 16'(ok), 16'h1);
            word_p1 = vecs[v].w1;
            word_p2 = vecs[v].w2;
            plugged = vecs[v].plug;
            wait_fv(ok);
            check({vecs[v].name, "_fv"}, 16'(ok), 16'h1);
            check({vecs[v].name, "_b1"}, 16'(buttons_p1), 16'(vecs[v].e1));
            check({vecs[v].name, "_b2"}, 16'(buttons_p2), 16'(vecs[v].e2));
            check({vecs[v].name, "_present"}, 16'(present), 16'(vecs[v].ep));
        end

        // ---- randomized frames against the reference rules ----
        for (int r = 0; r < 8; r++) begin
            wait_fv(ok);
            w1 = {($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom), 12'($urandom)};
            w2 = {($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom), 12'($urandom)};
            plug = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
            word_p1 = w1;
            word_p2 = w2;
            plugged = plug;
            e1 = plug[0] ? w1 : 16'h0000;
            e2 = plug[1] ? w2 : 16'h0000;
            wait_fv(ok);
            check($sformatf("rnd%0d_fv", r), 16'(ok), 16'h1);
            check($sformatf("rnd%0d_b1", r), 16'(buttons_p1), 16'(exp_btn(e1)));
            check($sformatf("rnd%0d_b2", r), 16'(buttons_p2), 16'(exp_btn(e2)));
            check($sformatf("rnd%0d_present", r), 16'(present), 16'({exp_pres(e2), exp_pres(e1)}));
        end

        // ---- synchronizer latency at the sample point ----
        direct_val  = 2'b11;
        direct_mode = 1'b1;
        wait_latch_rise(ok);
        check("lead1_latch", 16'(ok), 16'h1);
        drive_lead(16'hFEEF, 16'hFFF7, 1);
        repeat (4) step();
        check("lead1_fv", 16'(frame_valid), 16'h1);
        check("lead1_b1", 16'(buttons_p1), 16'h0110);
        check("lead1_b2", 16'(buttons_p2), 16'h0110);
        wait_latch_rise(ok);
        check("lead3_latch", 16'(ok), 16'h1);
        drive_lead(16'hFEEF, 16'hFFF7, 3);
        repeat (4) step();
        check("lead3_fv", 16'(frame_valid), 16'h1);
        check("lead3_b1", 16'(buttons_p1), 16'h0008);
        check("lead3_present", 16'(present), 16'h3);
        direct_mode = 1'b0;

        // ---- reset in the middle of bit 7 ----
        word_p1 = 16'hFFF7;
        word_p2 = 16'hFFFF;
        plugged = 2'b11;
        wait_fv(ok);
        wait_fv(ok);
        check("mid_pre_b1", 16'(buttons_p1), 16'h0008);
        wait_latch_rise(ok);
        check("mid_latch", 16'(ok), 16'h1);
        repeat (66) step();
        check("mid_in_lo", 16'(pad_clk), 16'h0);
        rst = 1'b1;
        step();
        check("mid_clk", 16'(pad_clk), 16'h1);
        check("mid_latch_lo", 16'(pad_latch), 16'h0);
        check("mid_b1", 16'(buttons_p1), 16'h0);
        check("mid_b2", 16'(buttons_p2), 16'h0);
        check("mid_present", 16'(present), 16'(rst_pres));
        step();
        rst = 1'b0;
        fv_seen = 0;
        for (int k = 0; k < FV_AT; k++) begin
            step();
            if (k == 0) check("mid_relatch", 16'(pad_latch), 16'h1);
            if (frame_valid) fv_seen++;
        end
        check("mid_no_early_fv", 16'(fv_seen), 16'h0);
        step();
        check("mid_fv_136", 16'(frame_valid), 16'h1);
        check("mid_new_b1", 16'(buttons_p1), 16'h0008);

        // ---- steady buttons over three frames ----
        step();
        check("hold_fv_width", 16'(frame_valid), 16'h0);
        fv_seen = 0;
        changes = 0;
        for (int k = 0; k < 2 * POLL; k++) begin
            step();
            if (frame_valid) fv_seen++;
            if (buttons_p1 !== 12'h008) changes++;
        end
        check("hold_fv_cycles", 16'(fv_seen), 16'h2);
        check("hold_b1_stable", 16'(changes), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
